// File: rtl/serial_parity_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker_if
// Description : Bit-serial input and frame-result output bundle for
//               serial_parity_checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_parity_checker_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity_err;
    logic [7:0]        err_cnt;

    // Producer of serial bits and consumer of frame results.
    modport master (
        output in_valid,
        output in_bit,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_parity_err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_parity_err,
        output err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_checker
// Description : Deserialises DATA_W data bits (LSB first) plus a parity bit,
//               flags parity errors and keeps a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_checker #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_parity_checker_if.slave bus
);
    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_PAR  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_parity_err_q, out_parity_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              in_xfer;
    logic              out_xfer;
    logic              frame_err;

    assign in_xfer   = bus.in_valid && in_ready_q;
    assign out_xfer  = out_valid_q && bus.out_ready;
    // Folding in the parity bit leaves 0 for a good even frame; PARITY_ODD
    // flips the expectation.
    assign frame_err = acc_q ^ bus.in_bit ^ PARITY_ODD;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        acc_d            = acc_q;
        shift_d          = shift_q;
        in_ready_d       = in_ready_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_parity_err_d = out_parity_err_q;
        err_cnt_d        = err_cnt_q;

        case (state_q)
            ST_RECV: begin
                if (in_xfer) begin
                    shift_d[cnt_q] = bus.in_bit;
                    acc_d          = acc_q ^ bus.in_bit;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PAR;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_PAR: begin
                if (in_xfer) begin
                    out_data_d       = shift_q;
                    out_parity_err_d = frame_err;
                    out_valid_d      = 1'b1;
                    in_ready_d       = 1'b0;
                    state_d          = ST_HOLD;
                    if (frame_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end

            ST_HOLD: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    acc_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RECV;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean receive state.
                state_d     = ST_RECV;
                cnt_d       = '0;
                acc_d       = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RECV;
            cnt_q            <= '0;
            acc_q            <= 1'b0;
            shift_q          <= '0;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_parity_err_q <= 1'b0;
            err_cnt_q        <= 8'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            acc_q            <= acc_d;
            shift_q          <= shift_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_parity_err_q <= out_parity_err_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_parity_err = out_parity_err_q;
    assign bus.err_cnt        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_checker
// Description : Scoreboard bench for an even-parity and an odd-parity instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_checker;
    logic clk;
    logic rst;
    logic in_valid;
    logic in_bit;
    logic out_ready;
    logic sel_odd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_cnt;

    serial_parity_checker_if #(.DATA_W(8)) if_e ();
    serial_parity_checker_if #(.DATA_W(8)) if_o ();

    serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk (clk),
        .rst (rst),
        .bus (if_e)
    );

    serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk (clk),
        .rst (rst),
        .bus (if_o)
    );

    assign if_e.in_valid  = in_valid & ~sel_odd;
    assign if_o.in_valid  = in_valid & sel_odd;
    assign if_e.in_bit    = in_bit;
    assign if_o.in_bit    = in_bit;
    assign if_e.out_ready = out_ready & ~sel_odd;
    assign if_o.out_ready = out_ready & sel_odd;

    wire       cur_in_ready  = sel_odd ? if_o.in_ready       : if_e.in_ready;
    wire       cur_out_valid = sel_odd ? if_o.out_valid      : if_e.out_valid;
    wire [7:0] cur_out_data  = sel_odd ? if_o.out_data       : if_e.out_data;
    wire       cur_err       = sel_odd ? if_o.out_parity_err : if_e.out_parity_err;
    wire [7:0] cur_err_cnt   = sel_odd ? if_o.err_cnt        : if_e.err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one result transfer per falling edge with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && cur_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got data 0x%0h with no expected frame", cur_out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_out_data", {24'd0, cur_out_data}, {24'd0, e.data});
                check("sb_parity_err", {31'd0, cur_err}, {31'd0, e.err});
                check("sb_err_cnt", {24'd0, cur_err_cnt}, {24'd0, e.cnt});
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cur_in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cur_in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready 0 required 1");
        end
    endtask

    // Sends 8 data bits LSB first then the parity bit; gap idle cycles before
    // each bit carry the inverted bit value, which must be ignored.
    task automatic send_frame(input logic [7:0] data, input logic par, input int gap);
        logic b;
        logic err;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? data[i] : par;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_bit   = ~b;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_bit   = b;
            wait_ready();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        err = (^data) ^ par ^ sel_odd;
        if (err && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
        e.data = data;
        e.err  = err;
        e.cnt  = model_cnt;
        exp_q.push_back(e);
        check("latency_out_valid", {31'd0, cur_out_valid}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        sel_odd   = 1'b0;
        model_cnt = 8'd0;
        #3;
        check("rst_in_ready", {31'd0, cur_in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, cur_out_valid}, 32'd0);
        check("rst_out_data", {24'd0, cur_out_data}, 32'd0);
        check("rst_parity_err", {31'd0, cur_err}, 32'd0);
        check("rst_err_cnt", {24'd0, cur_err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Good even frame.
        send_frame(8'hA5, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Bad frame held under back-pressure, with input offered during HOLD.
        out_ready = 1'b0;
        send_frame(8'h01, 1'b0, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", {31'd0, cur_out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, cur_in_ready}, 32'd0);
            check("hold_out_data", {24'd0, cur_out_data}, 32'h01);
            check("hold_parity_err", {31'd0, cur_err}, 32'd1);
            check("hold_err_cnt", {24'd0, cur_err_cnt}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_out_valid", {31'd0, cur_out_valid}, 32'd0);
        check("release_in_ready", {31'd0, cur_in_ready}, 32'd1);

        // Gaps between bits give the same result.
        send_frame(8'h3C, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while a bad result is pending.
        out_ready = 1'b0;
        send_frame(8'h80, 1'b0, 0);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, cur_out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, cur_in_ready}, 32'd1);
        check("arst_err_cnt", {24'd0, cur_err_cnt}, 32'd0);
        exp_q.delete();
        model_cnt = 8'd0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset mid-frame leaves no residue.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midframe_rst_in_ready", {31'd0, cur_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        send_frame(8'h0F, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Odd-parity instance: all-zero frames with parity 0 always fail.
        sel_odd = 1'b1;
        rst     = 1'b1;
        exp_q.delete();
        model_cnt = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int f = 1; f <= 260; f++) begin
            send_frame(8'h00, 1'b0, 0);
            if (f == 255) check("sat_cnt_at_255", {24'd0, cur_err_cnt}, 32'd255);
        end
        check("sat_cnt_at_260", {24'd0, cur_err_cnt}, 32'd255);

        for (int n = 0; n < 50 && exp_q.size() > 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Serial-input frame receiver that consumes one bit per handshake and folds each bit into a running 1-bit XOR accumulator.
- Each frame is DATA_W data bits (LSB first) followed by one parity bit.
- Outputs the deserialised word, a parity-error flag, and a saturating error count.
- Sits directly downstream of the 2-input XOR stage; the XOR is applied iteratively, one bit per cycle.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..16).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; forces all state and outputs to reset values immediately.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data/parity bit.
- in_ready  output  1  block can accept a bit this cycle.
- out_valid  output  1  frame result held on out_data/out_parity_err.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  received data word; bit 0 = first bit received.
- out_parity_err  output  1  1 = parity check failed for this frame.
- err_cnt  output  8  count of failed frames, saturating at 255.

Behaviour:
- Reset values: state=RECV, bit counter=0, accumulator=0, shift register=0, in_ready=1, out_valid=0, out_data=0, out_parity_err=0, err_cnt=0.
- Input transfer occurs when in_valid && in_ready on a rising edge. Output transfer occurs when out_valid && out_ready.
- FSM states:
  - RECV: in_ready=1. Each transfer stores in_bit at shift-register position [cnt], toggles acc ^= in_bit, and increments cnt. On the transfer with cnt==DATA_W-1, go to PAR and clear cnt.
  - PAR: in_ready=1. On transfer, compute err = acc ^ in_bit ^ PARITY_ODD. Register out_data=shift register and out_parity_err=err, set out_valid=1, go to HOLD. If err, err_cnt increments at the same edge unless already 255.
  - HOLD: in_ready=0; out_valid, out_data and out_parity_err remain stable. On output transfer, at the next edge: out_valid=0, acc=0, cnt=0, state=RECV. out_data and out_parity_err keep their last values (don't-care while out_valid=0).
- Latency: out_valid rises on the edge that accepts the parity bit, i.e. it is visible the cycle after the parity handshake.
- Throughput: at best DATA_W+1 input cycles plus 1 output cycle per frame. HOLD never accepts input, even when out_ready=1 in the same cycle.
- in_valid=0 cycles are idle: no state change, and no timeout (gaps of any length are allowed mid-frame).
- in_bit is ignored whenever no input transfer occurs.
- out_ready is ignored outside HOLD.
- Reset asserted mid-frame or during HOLD discards the partial frame or pending result and returns to reset values immediately. err_cnt is also cleared.
- err_cnt at 255 stays at 255 on further errors. It wraps only via rst.
- Counter width is clog2(DATA_W) bits. cnt never exceeds DATA_W-1.
- Parity arithmetic is a pure 1-bit XOR reduction. Even parity means the XOR of all DATA_W+1 bits must equal 0; odd parity means it must equal 1.

Test Plan:
- Reset check: rst=1 mid-sim with in_valid=1 → in_ready=1, out_valid=0, err_cnt=0 within the same cycle, no clock edge needed.
- Good even frame (PARITY_ODD=0): data 8'hA5 sent LSB first (1,0,1,0,0,1,0,1), then parity 0 → out_valid=1 one cycle after the parity transfer; out_data=8'hA5, out_parity_err=0, err_cnt=0.
- Bad frame with back-pressure: data 8'h01, then parity 0, with out_ready held 0 for 5 cycles → out_parity_err=1, err_cnt=1. Outputs stay stable and in_ready=0 for all 5 cycles. After out_ready=1 for one cycle, out_valid=0 and in_ready=1.
- Input gaps: 8'h3C sent with in_valid=0 for 3 cycles between every bit, parity 0 → same result as no gaps: out_data=8'h3C, out_parity_err=0.
- Reset mid-frame: send 4 bits of 8'hFF, pulse rst, then send a full frame 8'h0F with parity 0 → out_data=8'h0F, out_parity_err=0 (no residue from the aborted frame).
- Saturation and odd parity (PARITY_ODD=1): send 260 frames of 8'h00 with parity 0 → every frame flags out_parity_err=1; err_cnt reads 255 after frame 255 and stays 255 through frame 260.
